cpu_clock_ctrl: RTL and testbench

Run/halt/single-step controller for the Tomasulo core's execution clock. It debounces the board push-buttons and produces a one-cycle clock-enable, `cpu_en`, that the core qualifies all state updates with. The enable runs either as a free-running low-rate tick or as one pulse per button press. The core can also stop the tick on its own through `halt_req`. The core stays on the single system clock; no derived clock is ever generated.

---
 rtl/cpu_clock_ctrl.sv | 134 +++++++++++++
 tb/tb_cpu_clock_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/cpu_clock_ctrl.sv
// Run/halt/single-step execution-enable controller with debounced push-buttons.
// Define CLK_CTRL_CYCLE_COUNT_EN to add the cycle_count output and its counter.

module cpu_clock_ctrl_btn #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1, sync2, stable, stable_d, armed;
    logic [1:0]    settle;
    logic [CW-1:0] cnt;

    // armed is only set once the synchronizer holds a real low sample after reset,
    // so a button held through reset release never yields a press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            settle   <= '0;
            armed    <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
            press    <= 1'b0;
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            settle <= {settle[0], 1'b1};
            if (settle[1] && !sync2)
                armed <= 1'b1;
            if (sync2 == stable)
                cnt <= '0;
            else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
                stable <= sync2;
                cnt    <= '0;
            end else
                cnt <= cnt + CW'(1);
            stable_d <= stable;
            press    <= stable & ~stable_d & armed;
        end
    end
endmodule

module cpu_clock_ctrl #(
    parameter int unsigned CLK_HZ          = 100_000_000,
    parameter int unsigned RUN_HZ          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btnU,
    input  logic        btnC,
    input  logic        halt_req,
    output logic        cpu_en,
    output logic        running
`ifdef CLK_CTRL_CYCLE_COUNT_EN
    ,
    output logic [31:0] cycle_count
`endif
);
    localparam int unsigned TICK_DIV = CLK_HZ / RUN_HZ;
    localparam int unsigned TW       = $clog2(TICK_DIV);

    typedef enum logic {HALT, RUN} state_t;

    state_t        state, state_n;
    logic [TW-1:0] tick, tick_n;
    logic          wrap, wrap_n, en_n;
    logic          press_u, press_c;

    cpu_clock_ctrl_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_u (
        .clk(clk), .reset(reset), .raw(btnU), .press(press_u)
    );
    cpu_clock_ctrl_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_c (
        .clk(clk), .reset(reset), .raw(btnC), .press(press_c)
    );

    // wrap delays the tick enable by one cycle so a halt arriving on the
    // wrap cycle can still suppress it.
    always_comb begin
        state_n = state;
        tick_n  = '0;
        wrap_n  = 1'b0;
        en_n    = 1'b0;
        case (state)
            HALT: begin
                if (press_c)
                    state_n = RUN;
                else if (press_u)
                    en_n = 1'b1;
            end
            RUN: begin
                if (press_c || halt_req)
                    state_n = HALT;
                else begin
                    en_n   = wrap;
                    wrap_n = (tick == TW'(TICK_DIV - 1));
                    tick_n = wrap_n ? '0 : tick + TW'(1);
                end
            end
            default: state_n = HALT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= HALT;
            tick   <= '0;
            wrap   <= 1'b0;
            cpu_en <= 1'b0;
        end else begin
            state  <= state_n;
            tick   <= tick_n;
            wrap   <= wrap_n;
            cpu_en <= en_n;
        end
    end

    assign running = (state == RUN);

`ifdef CLK_CTRL_CYCLE_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cycle_count <= '0;
        else if (cpu_en)
            cycle_count <= cycle_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Directed vector bench for cpu_clock_ctrl (TICK_DIV=10, DEBOUNCE_CYCLES=4).
module tb_cpu_clock_ctrl;
    logic clk = 1'b0;
    logic reset, btnU, btnC, halt_req;
    logic cpu_en, running;
`ifdef CLK_CTRL_CYCLE_COUNT_EN
    logic [31:0] cycle_count;
`endif

    always #5 clk = ~clk;

    cpu_clock_ctrl #(.CLK_HZ(100), .RUN_HZ(10), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk),
        .reset(reset),
        .btnU(btnU),
        .btnC(btnC),
        .halt_req(halt_req),
        .cpu_en(cpu_en),
        .running(running)
`ifdef CLK_CTRL_CYCLE_COUNT_EN
        ,
        .cycle_count(cycle_count)
`endif
    );

    typedef struct packed {
        logic u;
        logic c;
        logic h;
        logic en;
        logic run;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_cc = 0;

    task automatic add(input logic u, input logic c, input logic h,
                       input logic en, input logic run, input int n);
        for (int k = 0; k < n; k++) vq.push_back('{u, c, h, en, run});
    endtask

    task automatic check_bit(input string name, input int idx, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s[%0d]: got %0b expected %0b", name, idx, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic check_cc(input string name);
`ifdef CLK_CTRL_CYCLE_COUNT_EN
        check_int({name, ".cycle_count"}, int'(cycle_count), exp_cc);
`endif
    endtask

    // vector i: inputs sampled at relative edge i, outputs checked just after it
    task automatic run_table(input string name);
        for (int i = 0; i < vq.size(); i++) begin
            btnU     = vq[i].u;
            btnC     = vq[i].c;
            halt_req = vq[i].h;
            @(posedge clk); #1;
            check_bit({name, ".cpu_en"}, i, cpu_en, vq[i].en);
            check_bit({name, ".running"}, i, running, vq[i].run);
            if (vq[i].en) exp_cc++;
        end
        btnU = 1'b0; btnC = 1'b0; halt_req = 1'b0;
        vq.delete();
        check_cc(name);
    endtask

    task automatic count_en(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            if (cpu_en) cnt++;
        end
    endtask

    int pulses;

    initial begin
        reset = 1'b1; btnU = 1'b0; btnC = 1'b0; halt_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_bit("in_reset.cpu_en", i, cpu_en, 1'b0);
            check_bit("in_reset.running", i, running, 1'b0);
        end
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            check_bit("idle.cpu_en", i, cpu_en, 1'b0);
            check_bit("idle.running", i, running, 1'b0);
        end
        check_cc("idle");

        // single step: pulse exactly at t+8
        add(1, 0, 0, 0, 0, 8); add(1, 0, 0, 1, 0, 1); add(1, 0, 0, 0, 0, 11);
        add(0, 0, 0, 0, 0, 10);
        run_table("step");

        // bounce shorter than the debounce window
        for (int r = 0; r < 5; r++) begin
            add(1, 0, 0, 0, 0, 3); add(0, 0, 0, 0, 0, 1);
        end
        add(0, 0, 0, 0, 0, 12);
        run_table("bounce");

        // run: first pulse 11 cycles after running rises, then every 10; stop on wrap cycle
        add(0, 1, 0, 0, 0, 8); add(0, 0, 0, 0, 1, 11); add(0, 0, 0, 1, 1, 1);
        for (int p = 0; p < 4; p++) begin
            add(0, 0, 0, 0, 1, 9); add(0, 0, 0, 1, 1, 1);
        end
        add(0, 1, 0, 0, 1, 8); add(0, 0, 0, 0, 0, 12);
        run_table("run_stop");

        // core halt on the tick-wrap cycle, then a step still works
        add(0, 1, 0, 0, 0, 8); add(0, 0, 0, 0, 1, 10); add(0, 0, 1, 0, 0, 1);
        add(0, 0, 0, 0, 0, 6); add(1, 0, 0, 0, 0, 8); add(1, 0, 0, 1, 0, 1);
        add(1, 0, 0, 0, 0, 1); add(0, 0, 0, 0, 0, 11);
        run_table("core_halt");

        // simultaneous presses in HALT, step press ignored in RUN, plain halt_req
        add(1, 1, 0, 0, 0, 8); add(1, 1, 0, 0, 1, 2); add(0, 0, 0, 0, 1, 9);
        add(0, 0, 0, 1, 1, 1); add(1, 0, 0, 0, 1, 9); add(1, 0, 0, 1, 1, 1);
        add(0, 0, 0, 0, 1, 9); add(0, 0, 0, 1, 1, 1); add(0, 0, 0, 0, 1, 2);
        add(0, 0, 1, 0, 0, 1); add(0, 0, 0, 0, 0, 10);
        run_table("conflict");

        // reset mid-run and mid-debounce, with btnU held through reset release
        add(0, 1, 0, 0, 0, 8); add(0, 0, 0, 0, 1, 8);
        run_table("prep");
        btnU = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_bit("pre_reset.running", 0, running, 1'b1);
        reset = 1'b1;
        #1;
        check_bit("async_reset.running", 0, running, 1'b0);
        check_bit("async_reset.cpu_en", 0, cpu_en, 1'b0);
        exp_cc = 0;
        check_cc("async_reset");
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        count_en(20, pulses);
        check_int("held_through_reset.pulses", pulses, 0);
        btnU = 1'b0;
        count_en(12, pulses);
        check_int("release_after_reset.pulses", pulses, 0);
        btnU = 1'b1;
        count_en(10, pulses);
        btnU = 1'b0;
        check_int("repress_after_reset.pulses", pulses, 1);
        exp_cc = exp_cc + pulses;
        count_en(10, pulses);
        check_int("after_repress.pulses", pulses, 0);
        check_bit("after_repress.running", 0, running, 1'b0);
        check_cc("after_repress");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
